// File: rtl/nx_ram_1r1w_init.sv
// nx_ram_1r1w_init: 1-read/1-write RAM with lane write enables and a hardware init sweep.
// Latency: reads return RD_LAT cycles after rd_en; oob_err pulses the cycle after the access.
// Backpressure: none; while init_done=0 all accesses are silently dropped.
// Ports: clk/rst_n (async active-low); init_req/init_done (re-init handshake);
//        wr_en/wr_add/wr_din/wr_bwe (lane-masked write); rd_en/rd_add -> rd_vld/rd_dout;
//        oob_err (address >= DEPTH on either port, one pulse per cycle).
module nx_ram_1r1w_init #(
  parameter int unsigned      WIDTH    = 64,
  parameter int unsigned      BWEWIDTH = WIDTH,
  parameter int unsigned      DEPTH    = 256,
  parameter int unsigned      RD_LAT   = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter bit               BYPASS   = 1'b1,
  localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_req,
  output logic                init_done,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_add,
  input  logic [WIDTH-1:0]    wr_din,
  input  logic [BWEWIDTH-1:0] wr_bwe,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_add,
  output logic [WIDTH-1:0]    rd_dout,
  output logic                rd_vld,
  output logic                oob_err
);

  localparam int unsigned   LW      = WIDTH / BWEWIDTH;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Storage has no reset; contents are defined only by the init sweep.
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_oob, rd_oob;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_word;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             rd_acc;
  logic             oob_d, oob_q;
  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_dat_q;

  assign wr_oob = ({1'b0, wr_add} >= DEPTH_W);
  assign rd_oob = ({1'b0, rd_add} >= DEPTH_W);

  // Lane merge of the incoming write onto the current entry contents.
  always_comb begin
    wr_merged = mem[wr_add];
    for (int k = 0; k < int'(BWEWIDTH); k++) begin
      if (wr_bwe[k]) wr_merged[k*LW +: LW] = wr_din[k*LW +: LW];
    end
  end

  // Same-address collision: BYPASS selects post-write (merged) vs pre-write data.
  // Out-of-range reads return zero.
  always_comb begin
    rd_word = mem[rd_add];
    if (BYPASS && wr_en && !wr_oob && (wr_add == rd_add)) rd_word = wr_merged;
    if (rd_oob) rd_word = '0;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state; init_req during INIT is ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM: outputs; in INIT the write port is owned by the sweep
  always_comb begin
    init_done = 1'b0;
    mem_we    = 1'b1;
    mem_wa    = cnt_q;
    mem_wd    = INIT_VAL;
    rd_acc    = 1'b0;
    oob_d     = 1'b0;
    if (state_q == ST_READY) begin
      init_done = 1'b1;
      mem_we    = wr_en && !wr_oob;
      mem_wa    = wr_add;
      mem_wd    = wr_merged;
      rd_acc    = rd_en;
      oob_d     = (wr_en && wr_oob) || (rd_en && rd_oob);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // First read stage; data only moves on a valid read so rd_dout holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      oob_q    <= 1'b0;
    end else begin
      s1_vld_q <= rd_acc;
      oob_q    <= oob_d;
      if (rd_acc) s1_dat_q <= rd_word;
    end
  end

  assign oob_err = oob_q;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             s2_vld_q;
      logic [WIDTH-1:0] s2_dat_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) s2_dat_q <= s1_dat_q;
        end
      end
      assign rd_vld  = s2_vld_q;
      assign rd_dout = s2_dat_q;
    end else begin : g_lat1
      assign rd_vld  = s1_vld_q;
      assign rd_dout = s1_dat_q;
    end
  endgenerate

endmodule

// File: tb/tb_nx_ram_1r1w_init.sv
module tb_nx_ram_1r1w_init;
  localparam int          DEPTH = 12;
  localparam logic [15:0] IV    = 16'hA5A5;
  localparam int          LAT_A = 2;  // dut_a: RD_LAT=2, BYPASS=1
  localparam int          LAT_B = 1;  // dut_b: RD_LAT=1, BYPASS=0

  logic        clk = 1'b0, rst_n = 1'b0, init_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_add = '0, rd_add = '0;
  logic [15:0] wr_din = '0;
  logic [1:0]  wr_bwe = '0;
  logic        done_a, vld_a, oob_a, done_b, vld_b, oob_b;
  logic [15:0] dout_a, dout_b;

  always #5 clk = ~clk;

  nx_ram_1r1w_init #(.WIDTH(16), .BWEWIDTH(2), .DEPTH(DEPTH), .RD_LAT(2),
                     .INIT_VAL(IV), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_done(done_a),
    .wr_en(wr_en), .wr_add(wr_add), .wr_din(wr_din), .wr_bwe(wr_bwe),
    .rd_en(rd_en), .rd_add(rd_add), .rd_dout(dout_a), .rd_vld(vld_a), .oob_err(oob_a));

  nx_ram_1r1w_init #(.WIDTH(16), .BWEWIDTH(2), .DEPTH(DEPTH), .RD_LAT(1),
                     .INIT_VAL(IV), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_done(done_b),
    .wr_en(wr_en), .wr_add(wr_add), .wr_din(wr_din), .wr_bwe(wr_bwe),
    .rd_en(rd_en), .rd_add(rd_add), .rd_dout(dout_b), .rd_vld(vld_b), .oob_err(oob_b));

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int due; logic [15:0] dat; } exp_t;
  exp_t        qa[$], qb[$];
  int          oq[$];
  logic [15:0] ref_mem [DEPTH];
  int          remaining = DEPTH;
  bit          m_done = 1'b0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  logic [15:0] last_a = '0, last_b = '0;

  // Model sees the inputs sampled at each rising edge; cyc numbers the edges.
  always @(posedge clk) begin
    exp_t        ea, eb;
    logic [15:0] nw;
    bit          rd_o, wr_o;
    cyc++;
    if (!rst_n) begin
      remaining = DEPTH;
      m_done    = 1'b0;
      qa.delete(); qb.delete(); oq.delete();
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
      end
      m_done = (remaining == 0);
    end else begin
      rd_o = (int'(rd_add) >= DEPTH);
      wr_o = (int'(wr_add) >= DEPTH);
      nw   = '0;
      if (wr_en && !wr_o) begin
        nw = ref_mem[wr_add];
        for (int k = 0; k < 2; k++) if (wr_bwe[k]) nw[k*8 +: 8] = wr_din[k*8 +: 8];
      end
      if (rd_en) begin
        eb.dat = rd_o ? 16'h0 : ref_mem[rd_add];
        ea.dat = (wr_en && !wr_o && !rd_o && wr_add == rd_add) ? nw : eb.dat;
        ea.due = cyc + LAT_A - 1;
        eb.due = cyc + LAT_B - 1;
        qa.push_back(ea);
        qb.push_back(eb);
      end
      if (wr_en && !wr_o) ref_mem[wr_add] = nw;
      if ((wr_en && wr_o) || (rd_en && rd_o)) oq.push_back(cyc);
      if (init_req) begin
        remaining = DEPTH;
        m_done    = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_port(input bit d, input logic vld, input logic [15:0] dout);
    exp_t e;
    bit   have, exp_v;
    have = d ? (qb.size() > 0) : (qa.size() > 0);
    e.due = 0; e.dat = '0;
    if (have) e = d ? qb[0] : qa[0];
    exp_v = have && (e.due == cyc);
    chk(d ? "rd_vld_b" : "rd_vld_a", vld, exp_v);
    if (have && e.due <= cyc) begin
      if (d) void'(qb.pop_front()); else void'(qa.pop_front());
    end
    if (exp_v) begin
      chk(d ? "rd_dout_b" : "rd_dout_a", dout, e.dat);
      if (d) last_b = e.dat; else last_a = e.dat;
    end else begin
      chk(d ? "rd_hold_b" : "rd_hold_a", dout, d ? last_b : last_a);
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge.
  always @(negedge clk) begin
    bit exp_oob;
    if (!rst_n) begin
      chk("reset_outs", {done_a, vld_a, oob_a, done_b, vld_b, oob_b, dout_a, dout_b}, 64'h0);
      last_a = '0;
      last_b = '0;
    end else begin
      chk("init_done_a", done_a, m_done);
      chk("init_done_b", done_b, m_done);
      chk_port(1'b0, vld_a, dout_a);
      chk_port(1'b1, vld_b, dout_b);
      exp_oob = (oq.size() > 0) && (oq[0] == cyc);
      if (oq.size() > 0 && oq[0] <= cyc) void'(oq.pop_front());
      chk("oob_err_a", oob_a, exp_oob);
      chk("oob_err_b", oob_b, exp_oob);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit we, input int wa, input logic [15:0] wd, input logic [1:0] be,
                      input bit re, input int ra, input bit ir);
    wr_en = we; wr_add = 4'(wa); wr_din = wd; wr_bwe = be;
    rd_en = re; rd_add = 4'(ra); init_req = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 16'h0, 2'b00, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int wa, ra;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(14);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 16'h0, 2'b00, 1'b1, i, 1'b0);
    idle(3);
    // partial lane write then read back
    step(1'b1, 3, 16'h1234, 2'b01, 1'b0, 0, 1'b0);
    step(1'b0, 0, 16'h0, 2'b00, 1'b1, 3, 1'b0);
    idle(3);
    // same-cycle write/read collision
    step(1'b1, 5, 16'hBEEF, 2'b11, 1'b1, 5, 1'b0);
    idle(3);
    // out-of-range write, read, and both together
    step(1'b1, 13, 16'hFFFF, 2'b11, 1'b0, 0, 1'b0);
    idle(2);
    step(1'b0, 0, 16'h0, 2'b00, 1'b1, 12, 1'b0);
    idle(2);
    step(1'b1, 15, 16'h0F0F, 2'b11, 1'b1, 14, 1'b0);
    idle(2);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 16'h0, 2'b00, 1'b1, i, 1'b0);
    idle(3);
    // re-init with a read accepted in the same cycle as init_req
    step(1'b1, 0, 16'h1111, 2'b11, 1'b0, 0, 1'b0);
    step(1'b0, 0, 16'h0, 2'b00, 1'b1, 0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, $urandom_range(0, 15), 16'($urandom), 2'b11, 1'b1, $urandom_range(0, 15),
           1'($urandom_range(0, 1)));
    step(1'b0, 0, 16'h0, 2'b00, 1'b1, 0, 1'b0);
    idle(3);
    // reset with a read in flight
    step(1'b0, 0, 16'h0, 2'b00, 1'b1, 5, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(14);
    // reset in the middle of the init sweep (entry counter at 6)
    step(1'b0, 0, 16'h0, 2'b00, 1'b0, 0, 1'b1);
    idle(6);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 16'h0, 2'b00, 1'b1, i, 1'b0);
    idle(4);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 16'h0, 2'b00, 1'b1, i, 1'b0);
    idle(3);
    // randomized traffic with occasional re-init and address collisions
    for (int n = 0; n < 800; n++) begin
      wa = $urandom_range(0, 15);
      ra = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ra, ($urandom_range(0, 63) == 0));
    end
    idle(5);
    chk("scoreboard_drained", 64'(qa.size() + qb.size() + oq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nx_ram_1r1w_init.md
NX_RAM_1R1W_INIT -- requirements
Module: nx_ram_1r1w_init

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data width in bits.
REQ-002 SHALL have parameter BWEWIDTH, default WIDTH: number of write-enable lanes; WIDTH % BWEWIDTH == 0; lane k covers bits [k*L +: L], L=WIDTH/BWEWIDTH.
REQ-003 SHALL have parameter DEPTH, default 256: number of entries; need not be a power of two.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter INIT_VAL, default 0: WIDTH-bit value written to every entry during init.
REQ-006 SHALL have parameter BYPASS, default 1: 1 = a same-cycle same-address read returns the new write data; 0 = it returns the old data.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 init_req  input  1  single-cycle request to re-initialise all entries.
REQ-010 init_done  output  1  high when the memory is initialised and accepting accesses.
REQ-011 wr_en  input  1  write strobe.
REQ-012 wr_add  input  clog2(DEPTH)  write address.
REQ-013 wr_din  input  WIDTH  write data.
REQ-014 wr_bwe  input  BWEWIDTH  per-lane write enable.
REQ-015 rd_en  input  1  read strobe.
REQ-016 rd_add  input  clog2(DEPTH)  read address.
REQ-017 rd_dout  output  WIDTH  read data.
REQ-018 rd_vld  output  1  read data valid, one cycle per accepted read.
REQ-019 oob_err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-020 The FSM SHALL have states INIT and READY; reset enters INIT with the init counter at 0.
REQ-021 In INIT the block SHALL write INIT_VAL to entry cnt each cycle, incrementing cnt, and SHALL enter READY the cycle after writing entry DEPTH-1 (DEPTH cycles in INIT).
REQ-022 init_done SHALL be 1 exactly while in READY.
REQ-023 init_req in READY SHALL re-enter INIT with cnt=0 on the next cycle; init_req while in INIT SHALL be ignored.
REQ-024 In INIT, wr_en and rd_en SHALL be ignored: no memory update, no rd_vld, no oob_err.
REQ-025 In READY, wr_en SHALL update only the lanes of mem[wr_add] whose wr_bwe bit is 1; the other lanes keep their value. wr_bwe=0 SHALL leave the entry unchanged.
REQ-026 In READY, rd_en at cycle N SHALL give rd_vld=1 and rd_dout=mem[rd_add] at cycle N+RD_LAT; back-to-back reads SHALL be fully pipelined, one per cycle.
REQ-027 When rd_vld=0, rd_dout SHALL hold its last value.
REQ-028 Same-cycle wr_en and rd_en to the same address: with BYPASS=1 rd_dout SHALL equal the lane-merged post-write word; with BYPASS=0 it SHALL equal the pre-write word.
REQ-029 An address >= DEPTH SHALL assert oob_err for one cycle. An out-of-range write SHALL be dropped. An out-of-range read SHALL still produce rd_vld, with rd_dout=0.
REQ-030 An out-of-range write and an out-of-range read in the same cycle SHALL produce one oob_err pulse.
REQ-031 Reads accepted before an init_req SHALL still complete with their pre-init data at their normal latency.

Reset
REQ-032 While rst_n=0: init_done=0, rd_vld=0, oob_err=0, rd_dout=0, read pipeline cleared, FSM=INIT, cnt=0.
REQ-033 Deassertion of rst_n during INIT SHALL restart initialisation from entry 0. Reads in flight when reset asserts SHALL be discarded.
REQ-034 Memory contents SHALL NOT be reset directly; only the INIT sequence defines them.

Verification (WIDTH=16, BWEWIDTH=2, DEPTH=12, INIT_VAL=16'hA5A5 unless noted)
REQ-035 Release reset -> init_done rises exactly 12 cycles later; reading all 12 entries returns 16'hA5A5 each.
REQ-036 Write 16'h1234 to entry 3 with bwe=2'b01, then read entry 3 with RD_LAT=2 -> rd_vld 2 cycles after rd_en, rd_dout=16'hA534.
REQ-037 Write 16'hBEEF to entry 5 and read entry 5 in the same cycle -> rd_dout=16'hBEEF with BYPASS=1; rd_dout=16'hA5A5 with BYPASS=0.
REQ-038 Write to address 13 -> one-cycle oob_err; no entry changes. Read address 12 -> rd_vld=1, rd_dout=0, one-cycle oob_err.
REQ-039 Pulse init_req after writing entry 0 -> init_done=0 for 12 cycles; rd_en/wr_en ignored during that window; entry 0 reads 16'hA5A5 afterwards.
REQ-040 Assert rst_n=0 at cnt=6, release it -> init_done stays 0 for a full 12 cycles after release; rd_vld=0 throughout.
